sobel_window_3x3: RTL and testbench
===================================

Name: sobel_window_3x3

Overview:
Streaming 3x3 neighbourhood generator between the RGB-to-grayscale stage and the Sobel gradient stage. Consumes one 8-bit grayscale pixel per valid cycle in raster order and stores the two previous image rows in line buffers. Emits a full 3x3 window for every interior pixel position. Border positions produce no window.

Parameters:
IMG_WIDTH, 640, pixels per row (>= 3)
IMG_HEIGHT, 480, rows per frame (>= 3)
PIX_W, 8, bits per pixel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
pix_i  in  PIX_W  grayscale pixel (grayscale_o of upstream stage)
pix_valid_i  in  1  pixel strobe (done_o of upstream stage); a pixel is accepted on every cycle this is high
sof_i  in  1  start of frame; qualified by pix_valid_i; marks the pixel as (row 0, col 0)
win_o  out  9*PIX_W  window; pixel k at bits [PIX_W*k +: PIX_W], k = 3*r + c, r=0 top row, c=0 left column
win_valid_o  out  1  win_o holds a valid interior window
frame_done_o  out  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset (clk edge with rst=1): col=0, row=0, win_o=0, win_valid_o=0, frame_done_o=0. Line buffer contents are not cleared. Row/col masking hides their contents.
- Counters refer to the incoming pixel. On an accepted pixel, col increments. At col=IMG_WIDTH-1, col wraps to 0 and row increments. At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- sof_i=1 with pix_valid_i=1: the pixel is treated as (0,0) regardless of the counters. Next counter value is (0,1). sof_i without pix_valid_i is ignored.
- Line buffers: lb0 holds the previous row and lb1 holds the row before that, each IMG_WIDTH x PIX_W. On an accepted pixel at column col:
  - read lb1[col] (top) and lb0[col] (middle)
  - write lb1[col] <= lb0[col] and lb0[col] <= pix_i
- The window shift register moves left by one column. The new right column is {top, middle, pix_i}, i.e. k=2,5,8.
- Latency: win_o/win_valid_o are registered exactly 1 cycle after the accepting edge.
- win_valid_o=1 iff the pixel accepted at the previous edge had row>=2 and col>=2. The window is then centred on (row-1, col-1).
- Windows straddling a row wrap (col 0,1) or using rows from a previous frame (row 0,1) are never flagged valid.
- Each frame produces (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.
- pix_valid_i=0: counters, line buffers and shift register hold. win_valid_o=0 and frame_done_o=0 on the next cycle. win_o holds its last value.
- frame_done_o=1 in the same cycle as the window for accepted pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Data is unsigned and passed through unmodified. There is no arithmetic on pixel values.
- Reset mid-frame: all outputs are 0 on the next cycle. The next accepted pixel is (0,0) whether or not sof_i is asserted.

Decomposition:
- Shared package (sobel_pkg):
  - PIX_W
  - WIN_TAPS = 9
  - WIN_W = 9*PIX_W
  - tap index constants TL=0, TC=1, TR=2, ML=3, MC=4, MR=5, BL=6, BC=7, BR=8
  - these constants are shared with the downstream Sobel stage
- Sub-module line_buffer: parameters DEPTH and WIDTH, single write port, combinational read at the write address. It is instantiated twice.
- Counters, masking and the window register stay in the top module.

Test Plan:
1. IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 16*row+col, sof on the first pixel, continuous valid.
   - Required: exactly 6 windows.
   - First window, one cycle after pixel (2,2): taps 0..8 = 0x00,01,02,10,11,12,20,21,22.
   - Last window = 0x12,13,14,22,23,24,32,33,34, with frame_done_o=1.
2. Same frame with pix_valid_i toggling 1,0,0,1.
   - Required: identical window sequence.
   - win_valid_o low during gaps; win_o unchanged during gaps.
3. Two back-to-back frames, second frame pixel = 0xF0 ^ (16*row+col).
   - Required: 6 windows from frame 2.
   - None contains frame-1 data.
   - No valid window on frame-2 rows 0-1.
4. sof_i asserted at pixel (2,3) of a frame.
   - Required: counters restart, and the following 2*IMG_WIDTH+2 pixels produce no valid window.
   - The next window contains only post-sof pixels.
5. rst for 1 cycle at pixel (3,1).
   - Required: next-cycle win_o=0, win_valid_o=0, frame_done_o=0.
   - A new frame without sof_i yields 6 correct windows.
6. All pixels 0xFF, W=3, H=3.
   - Required: exactly one window, all taps 0xFF, with frame_done_o=1 in the same cycle.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg
// Constants shared by the 3x3 window generator and the downstream Sobel
// gradient stage: pixel width, window width and the tap index map.
// Tap k of a window sits at bits [PIX_W*k +: PIX_W], with k = 3*row + col,
// row 0 at the top and col 0 at the left.
package sobel_pkg;

  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = WIN_TAPS * PIX_W;

  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

endpackage

// File: rtl/sobel_window_3x3_line_buffer.sv
// line_buffer
// One image row of pixel storage. Single write port; the read port is
// combinational at the write address, so a read-then-overwrite of the same
// column happens in one cycle (the old value is seen before the edge).
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   addr   column address (read and write)
//   wdata  data written at addr on the edge when we=1
//   rdata  current contents at addr
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: stale contents are hidden by row masking in the caller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_window_3x3.sv
// sobel_window_3x3
// Streaming 3x3 neighbourhood generator. Takes one grayscale pixel per valid
// cycle in raster order, keeps the two previous rows in line buffers and
// emits a registered 3x3 window for every interior pixel position.
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   pix_i         incoming grayscale pixel
//   pix_valid_i   pixel strobe; a pixel is accepted every cycle it is high
//   sof_i         start of frame, qualified by pix_valid_i; pixel is (0,0)
//   win_o         window, tap k at [PIX_W*k +: PIX_W], k = 3*r + c
//   win_valid_o   win_o holds a window centred on an interior pixel
//   frame_done_o  pulses with the last window of a frame
module sobel_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = sobel_pkg::PIX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_i,
  input  logic               pix_valid_i,
  input  logic               sof_i,
  output logic [9*PIX_W-1:0] win_o,
  output logic               win_valid_o,
  output logic               frame_done_o
);

  import sobel_pkg::*;

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [COL_W-1:0]   cur_col;
  logic [ROW_W-1:0]   cur_row;
  logic [PIX_W-1:0]   top_pix;
  logic [PIX_W-1:0]   mid_pix;
  logic [9*PIX_W-1:0] win_q;
  logic [9*PIX_W-1:0] win_next;
  logic               lb_we;

  // Position of the pixel being accepted this cycle; sof forces (0,0).
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (sof_i) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign lb_we = pix_valid_i & ~rst;

  // lb0 holds the previous row, lb1 the row before it. lb1 is refilled from
  // lb0's outgoing value so the two rows age together.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (cur_col),
    .wdata (pix_i),
    .rdata (mid_pix)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (lb_we),
    .addr  (cur_col),
    .wdata (mid_pix),
    .rdata (top_pix)
  );

  // Shift the window one column left and insert the new right column.
  always_comb begin
    win_next = win_q;
    win_next[PIX_W*TL +: PIX_W] = win_q[PIX_W*TC +: PIX_W];
    win_next[PIX_W*TC +: PIX_W] = win_q[PIX_W*TR +: PIX_W];
    win_next[PIX_W*TR +: PIX_W] = top_pix;
    win_next[PIX_W*ML +: PIX_W] = win_q[PIX_W*MC +: PIX_W];
    win_next[PIX_W*MC +: PIX_W] = win_q[PIX_W*MR +: PIX_W];
    win_next[PIX_W*MR +: PIX_W] = mid_pix;
    win_next[PIX_W*BL +: PIX_W] = win_q[PIX_W*BC +: PIX_W];
    win_next[PIX_W*BC +: PIX_W] = win_q[PIX_W*BR +: PIX_W];
    win_next[PIX_W*BR +: PIX_W] = pix_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (pix_valid_i) begin
      if (cur_col == COL_LAST) begin
        col_q <= '0;
        row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      end else begin
        col_q <= cur_col + 1'b1;
        row_q <= cur_row;
      end
      win_q <= win_next;
      // Rows 0-1 would pull stale line-buffer data; cols 0-1 straddle a wrap.
      win_valid_o  <= (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
      frame_done_o <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end else begin
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end
  end

  assign win_o = win_q;

endmodule

// File: tb/tb_sobel_window_3x3.sv
module tb_sobel_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a_pix, b_pix;
  logic        a_v, b_v, a_sof, b_sof;
  logic [71:0] a_win, b_win;
  logic        a_wv, b_wv, a_fd, b_fd;

  sobel_window_3x3 #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .PIX_W(8)) dut_a (
    .clk(clk), .rst(rst), .pix_i(a_pix), .pix_valid_i(a_v), .sof_i(a_sof),
    .win_o(a_win), .win_valid_o(a_wv), .frame_done_o(a_fd)
  );

  sobel_window_3x3 #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) dut_b (
    .clk(clk), .rst(rst), .pix_i(b_pix), .pix_valid_i(b_v), .sof_i(b_sof),
    .win_o(b_win), .win_valid_o(b_wv), .frame_done_o(b_fd)
  );

  typedef struct {
    bit          sel;
    bit          valid;
    bit          done;
    bit          chk_win;
    logic [71:0] win;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int win_count = 0;
  logic [71:0] first_win, done_win;
  bit done_seen;

  // Reference model: image stored by (row, col) of the current frame.
  int mw, mh, m_row, m_col;
  logic [7:0] img [0:7][0:7];
  bit hold_known;
  logic [71:0] hold_win;

  task automatic cmp(input string name, input logic [71:0] act, input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit r, input bit v, input bit sf, input logic [7:0] p);
    exp_t e;
    int rr, cc;
    rst   = r;
    a_v   = !s && v;  a_sof = !s && sf; a_pix = s ? 8'h00 : p;
    b_v   = s && v;   b_sof = s && sf;  b_pix = s ? p : 8'h00;
    e.sel = s; e.valid = 0; e.done = 0; e.chk_win = 0; e.win = '0;
    if (r) begin
      m_row = 0; m_col = 0;
      hold_known = 1; hold_win = '0;
      e.chk_win = 1;
    end else if (v) begin
      rr = sf ? 0 : m_row;
      cc = sf ? 0 : m_col;
      img[rr][cc] = p;
      if (rr >= 2 && cc >= 2) begin
        e.valid = 1;
        e.chk_win = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[8*(3*i+j) +: 8] = img[rr-2+i][cc-2+j];
        e.done = (rr == mh-1) && (cc == mw-1);
        hold_known = 1; hold_win = e.win;
      end else begin
        hold_known = 0;
      end
      m_col = cc + 1; m_row = rr;
      if (m_col == mw) begin
        m_col = 0; m_row = rr + 1;
        if (m_row == mh) m_row = 0;
      end
    end else begin
      e.chk_win = hold_known;
      e.win = hold_win;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit s, input int n);
    for (int i = 0; i < n; i++) step(s, 0, 0, 0, 8'h00);
  endtask

  // gaps=1 applies the valid pattern 1,0,0,1 repeated.
  task automatic frame(input bit s, input bit gaps, input logic [7:0] xv, input bit sof_first);
    int n;
    n = 0;
    for (int r = 0; r < mh; r++)
      for (int c = 0; c < mw; c++) begin
        step(s, 0, 1, sof_first && n == 0, xv ^ 8'((16*r + c) & 8'hFF));
        if (gaps && (n % 2 == 0)) idle(s, 2);
        n++;
      end
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    logic [71:0] w;
    logic wv, fd;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e  = q.pop_front();
        w  = e.sel ? b_win : a_win;
        wv = e.sel ? b_wv  : a_wv;
        fd = e.sel ? b_fd  : a_fd;
        cmp("win_valid", 72'(wv), 72'(e.valid));
        cmp("frame_done", 72'(fd), 72'(e.done));
        if (e.chk_win) cmp("win", w, e.win);
        if (wv === 1'b1) begin
          if (win_count == 0) first_win = w;
          if (fd === 1'b1) begin
            done_win = w;
            done_seen = 1;
          end
          win_count++;
        end
      end
    end
  end

  initial begin
    rst = 1; a_v = 0; b_v = 0; a_sof = 0; b_sof = 0; a_pix = 0; b_pix = 0;
    mw = 5; mh = 4; m_row = 0; m_col = 0; hold_known = 0; hold_win = '0;
    done_seen = 0;

    // Reset state
    step(0, 1, 0, 0, 8'h00);
    idle(0, 2);

    // 1: continuous frame
    win_count = 0; done_seen = 0;
    frame(0, 0, 8'h00, 1);
    idle(0, 2);
    cmp("t1_count", 72'(win_count), 72'd6);
    cmp("t1_first", first_win, 72'h22_21_20_12_11_10_02_01_00);
    cmp("t1_last", done_win, 72'h34_33_32_24_23_22_14_13_12);
    cmp("t1_done_seen", 72'(done_seen), 72'd1);

    // 2: same frame with valid gaps
    win_count = 0;
    frame(0, 1, 8'h00, 1);
    idle(0, 2);
    cmp("t2_count", 72'(win_count), 72'd6);
    cmp("t2_first", first_win, 72'h22_21_20_12_11_10_02_01_00);

    // 3: two back-to-back frames, second XOR 0xF0, no sof on the second
    win_count = 0;
    frame(0, 0, 8'h00, 1);
    frame(0, 0, 8'hF0, 0);
    idle(0, 2);
    cmp("t3_count", 72'(win_count), 72'd12);
    cmp("t3_last", done_win, 72'hC4_C3_C2_D4_D3_D2_E4_E3_E2);

    // 4: sof at (2,3)
    step(0, 0, 1, 1, 8'($urandom));
    for (int i = 1; i < 13; i++) step(0, 0, 1, 0, 8'($urandom));
    step(0, 0, 1, 1, 8'($urandom));
    win_count = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 8'($urandom));
    cmp("t4_quiet", 72'(win_count), 72'd0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 8'($urandom));
    idle(0, 2);
    cmp("t4_count", 72'(win_count), 72'd6);

    // 5: reset at (3,1), then a frame without sof
    frame(0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, i == 0, 8'($urandom));
    step(0, 1, 1, 0, 8'hAA);
    win_count = 0;
    frame(0, 0, 8'h5A, 0);
    idle(0, 2);
    cmp("t5_count", 72'(win_count), 72'd6);

    // 6: 3x3 image of 0xFF
    step(1, 1, 0, 0, 8'h00);
    mw = 3; mh = 3;
    win_count = 0; done_seen = 0;
    for (int i = 0; i < 9; i++) step(1, 0, 1, i == 0, 8'hFF);
    idle(1, 2);
    cmp("t6_count", 72'(win_count), 72'd1);
    cmp("t6_done", 72'(done_seen), 72'd1);
    cmp("t6_win", done_win, {9{8'hFF}});

    // Random traffic with gaps, stray sof and occasional reset
    mw = 5; mh = 4;
    step(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 400; i++) begin
      step(0, $urandom_range(99) == 0, $urandom_range(9) < 7,
           $urandom_range(29) == 0, 8'($urandom));
    end
    idle(0, 3);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
